board_ram_arbiter: RTL and testbench

Shares one single-port 1024x2 board RAM (one instance each for the "us" and "them" boards) between three users: the video read path (tile renderer), the game-logic port (placement, shots, firmware access) and an internal board-clear sequencer. Video has absolute priority so pixel timing is never disturbed. The clear sequencer is next, and the game port is served in the remaining free cycles through a req/ack handshake. The block sits between the board RAM and both the renderer and the game FSM.

---
 rtl/board_pkg.sv | 31 +++
 rtl/board_clear_seq.sv | 56 +++++
 rtl/board_ram_arbiter.sv | 135 +++++++++++++
 tb/tb_board_ram_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// board_pkg: shared definitions for the board RAM arbiter slice.
//   - tile codes (EMPTY/HIT/MISS/SHIP)
//   - default board dimensions and tile address field widths
//   - arbiter FSM state encodings
//   - tile_addr(): packs {x, y} into a RAM address
package board_pkg;

    localparam int BOARD_W_DEF = 10;
    localparam int BOARD_H_DEF = 10;
    localparam int X_W         = 5;
    localparam int Y_W         = 5;
    localparam int ADDR_W      = X_W + Y_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HIT   = 2'd1,
        MISS  = 2'd2,
        SHIP  = 2'd3
    } tile_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GL_CAP = 2'd1;
    localparam logic [1:0] ST_GL_ACK = 2'd2;
    localparam logic [1:0] ST_CLEAR  = 2'd3;

    function automatic logic [ADDR_W-1:0] tile_addr(input logic [X_W-1:0] x,
                                                    input logic [Y_W-1:0] y);
        return {x, y};
    endfunction

endpackage

// File: rtl/board_clear_seq.sv
// board_clear_seq: walks every tile of the board (y inner, x outer) while
// the arbiter grants it the RAM port, stalling on video cycles.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   active     clear owns the port whenever video does not
//   stall      video owns the RAM port this cycle (counters hold)
//   addr       tile address of the current clear write
//   last_wr    this cycle writes the final tile
//   done       one-cycle pulse the cycle after the final write
module board_clear_seq
    import board_pkg::*;
#(
    parameter int BOARD_W = BOARD_W_DEF,
    parameter int BOARD_H = BOARD_H_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active,
    input  logic              stall,
    output logic [ADDR_W-1:0] addr,
    output logic              last_wr,
    output logic              done
);

    localparam logic [X_W-1:0] X_LAST = X_W'(BOARD_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(BOARD_H - 1);

    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           wr;

    assign wr      = active & ~stall;
    assign last_wr = wr && (x == X_LAST) && (y == Y_LAST);
    assign addr    = tile_addr(x, y);

    // Counters wrap back to 0,0 after the last tile, so every clear starts
    // from the origin without a separate load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x    <= '0;
            y    <= '0;
            done <= 1'b0;
        end else begin
            done <= last_wr;
            if (wr) begin
                if (y == Y_LAST) begin
                    y <= '0;
                    x <= (x == X_LAST) ? '0 : x + 1'b1;
                end else begin
                    y <= y + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter: shares one single-port 1024x2 board RAM between the
// video read path (highest priority), the board-clear sequencer and the
// game-logic req/ack port.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   vid_rd_en, vid_addr, vid_data     video read port (1-cycle latency)
//   gl_req/we/addr/wdata              game request (held until gl_ack)
//   gl_ack, gl_rdata, gl_err          game completion, read data, reject flag
//   clr_start, clr_busy, clr_done     board-clear control/status
//   ram_addr/we/wdata, ram_rdata      RAM port (synchronous read)
// Optional feature: define BOARD_ARB_RANGE_CHECK_EN to reject game accesses
// with x >= BOARD_W or y >= BOARD_H (gl_err pulses with gl_ack).
module board_ram_arbiter
    import board_pkg::*;
#(
    parameter int BOARD_W = BOARD_W_DEF,
    parameter int BOARD_H = BOARD_H_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vid_rd_en,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [1:0]        vid_data,
    input  logic              gl_req,
    input  logic              gl_we,
    input  logic [ADDR_W-1:0] gl_addr,
    input  logic [1:0]        gl_wdata,
    output logic              gl_ack,
    output logic [1:0]        gl_rdata,
    output logic              gl_err,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [1:0]        ram_wdata,
    input  logic [1:0]        ram_rdata
);

    logic [1:0]        state;
    logic              rd_q;
    logic              err_q;
    logic              clr_active;
    logic              clr_last;
    logic [ADDR_W-1:0] clr_addr;
    logic              grant;
    logic              oor;

`ifdef BOARD_ARB_RANGE_CHECK_EN
    localparam logic [X_W-1:0] X_LAST = X_W'(BOARD_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(BOARD_H - 1);

    assign oor    = (gl_addr[ADDR_W-1:Y_W] > X_LAST) || (gl_addr[Y_W-1:0] > Y_LAST);
    assign gl_err = gl_ack & err_q;
`else
    assign oor    = 1'b0;
    assign gl_err = 1'b0;
`endif

    // A clear latched during GL_CAP/GL_ACK waits until the game transaction
    // has finished before it takes the port.
    assign clr_active = clr_busy && ((state == ST_IDLE) || (state == ST_CLEAR));
    assign grant      = !rst && (state == ST_IDLE) && !clr_busy && gl_req && !vid_rd_en;
    assign vid_data   = ram_rdata;
    assign gl_ack     = (state == ST_GL_ACK);

    board_clear_seq #(
        .BOARD_W(BOARD_W),
        .BOARD_H(BOARD_H)
    ) u_clear_seq (
        .clk    (clk),
        .rst    (rst),
        .active (clr_active),
        .stall  (vid_rd_en),
        .addr   (clr_addr),
        .last_wr(clr_last),
        .done   (clr_done)
    );

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = EMPTY;
        if (vid_rd_en) begin
            ram_addr = vid_addr;
        end else if (clr_active) begin
            ram_addr = clr_addr;
            ram_we   = 1'b1;
        end else if (!rst) begin
            ram_addr  = gl_addr;
            ram_we    = grant && gl_we && !oor;
            ram_wdata = gl_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            rd_q     <= 1'b0;
            err_q    <= 1'b0;
            gl_rdata <= '0;
            clr_busy <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_busy) begin
                        state <= clr_last ? ST_IDLE : ST_CLEAR;
                    end else if (grant) begin
                        state <= ST_GL_CAP;
                        rd_q  <= !gl_we;
                        err_q <= oor;
                    end
                end
                ST_GL_CAP: begin
                    if (err_q)
                        gl_rdata <= EMPTY;
                    else if (rd_q)
                        gl_rdata <= ram_rdata;
                    state <= ST_GL_ACK;
                end
                ST_GL_ACK: state <= ST_IDLE;
                ST_CLEAR:  if (clr_last) state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase

            // The final write wins over a coincident clr_start, which is
            // ignored because clr_busy is still set in that cycle.
            if (clr_last)
                clr_busy <= 1'b0;
            else if (clr_start)
                clr_busy <= 1'b1;
        end
    end

endmodule

// File: tb/tb_board_ram_arbiter.sv
module tb_board_ram_arbiter;
    import board_pkg::*;

    localparam int W = 10;
    localparam int H = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       vid_rd_en;
    logic [9:0] vid_addr;
    logic [1:0] vid_data;
    logic       gl_req;
    logic       gl_we;
    logic [9:0] gl_addr;
    logic [1:0] gl_wdata;
    logic       gl_ack;
    logic [1:0] gl_rdata;
    logic       gl_err;
    logic       clr_start;
    logic       clr_busy;
    logic       clr_done;
    logic [9:0] ram_addr;
    logic       ram_we;
    logic [1:0] ram_wdata;
    logic [1:0] ram_rdata;

    always #5 clk = ~clk;

    board_ram_arbiter #(.BOARD_W(W), .BOARD_H(H)) dut (
        .clk(clk), .rst(rst),
        .vid_rd_en(vid_rd_en), .vid_addr(vid_addr), .vid_data(vid_data),
        .gl_req(gl_req), .gl_we(gl_we), .gl_addr(gl_addr), .gl_wdata(gl_wdata),
        .gl_ack(gl_ack), .gl_rdata(gl_rdata), .gl_err(gl_err),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Behavioural single-port RAM, synchronous read.
    logic [1:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference board contents as seen by the game port (transaction level).
    int ref_b [1024];
    int pre_b [1024];

    typedef struct { int rdata; int err; } gl_exp_t;
    gl_exp_t gl_q [$];
    int      vid_q [$];
    int      wr_log [$];
    logic    vid_prev = 1'b0;
    longint  t_ack  = 0;
    longint  t_done = 0;

    always @(posedge clk) vid_prev <= vid_rd_en;

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_we) wr_log.push_back(int'(ram_addr) * 4 + int'(ram_wdata));
            if (vid_rd_en) check("ram_we_during_video", int'(ram_we), 0);
            if (gl_ack) begin
                t_ack = $time;
                if (gl_q.size() == 0) begin
                    check("unexpected_gl_ack", 1, 0);
                end else begin
                    gl_exp_t e;
                    e = gl_q.pop_front();
                    if (e.rdata >= 0) check("gl_rdata", int'(gl_rdata), e.rdata);
                    check("gl_err", int'(gl_err), e.err);
                end
            end
            if (clr_done) t_done = $time;
            if (vid_prev) begin
                if (vid_q.size() == 0) check("vid_queue_underflow", 1, 0);
                else check("vid_data", int'(vid_data), vid_q.pop_front());
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] ta(input int x, input int y);
        logic [9:0] a;
        a = {5'(x), 5'(y)};
        return a;
    endfunction

    // One game transaction; starts and ends just after a rising edge.
    task automatic gl_txn(input logic we, input logic [9:0] addr, input logic [1:0] d,
                          input int exp_lat, input int exp_err);
        gl_exp_t e;
        int lat;
        bit got;
        if (exp_err != 0) begin
            e.rdata = 0;
            e.err   = 1;
        end else if (we) begin
            e.rdata = -1;
            e.err   = 0;
            ref_b[addr] = int'(d);
        end else begin
            e.rdata = ref_b[addr];
            e.err   = 0;
        end
        gl_q.push_back(e);
        gl_req = 1'b1; gl_we = we; gl_addr = addr; gl_wdata = d;
        lat = 0;
        got = 0;
        while (lat < 1000) begin
            @(negedge clk);
            if (gl_ack) begin got = 1; break; end
            lat++;
        end
        if (!got) check("gl_ack_timeout", 0, 1);
        else if (exp_lat >= 0) check("gl_latency", lat, exp_lat);
        tick;
        gl_req = 1'b0;
        gl_we  = 1'b0;
    endtask

    task automatic prefill;
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                gl_txn(1'b1, ta(x, y), 2'($urandom_range(1, 3)), 2, 0);
    endtask

    task automatic start_clear_model;
        for (int i = 0; i < 1024; i++) pre_b[i] = ref_b[i];
        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++)
                ref_b[ta(x, y)] = 0;
    endtask

    function automatic int clear_order_errors(input int nwr);
        int bad;
        bad = 0;
        if (wr_log.size() != nwr) bad++;
        for (int i = 0; i < nwr && i < wr_log.size(); i++)
            if (wr_log[i] != int'(ta(i / H, i % H)) * 4) bad++;
        return bad;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, %0d checks so far", n_chk);
        $fatal(1);
    end

    initial begin
        int k, cleared, seen, x, y, idx;
        for (int i = 0; i < 1024; i++) ref_b[i] = 0;

        // Reset behaviour, with a write request pending to exercise gating
        rst = 1'b1; clr_start = 1'b0;
        vid_rd_en = 1'b0; vid_addr = 10'h0AB;
        gl_req = 1'b1; gl_we = 1'b1; gl_addr = 10'h155; gl_wdata = 2'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ram_we", int'(ram_we), 0);
        check("rst_ram_addr", int'(ram_addr), 0);
        check("rst_gl_ack", int'(gl_ack), 0);
        check("rst_gl_rdata", int'(gl_rdata), 0);
        check("rst_gl_err", int'(gl_err), 0);
        check("rst_clr_busy", int'(clr_busy), 0);
        check("rst_clr_done", int'(clr_done), 0);
        vid_rd_en = 1'b1;
        #1;
        check("rst_ram_addr_video", int'(ram_addr), 'h0AB);
        vid_rd_en = 1'b0; gl_req = 1'b0; gl_we = 1'b0;
        tick;
        rst = 1'b0;
        tick;

        // Write SHIP to {3,4}, then read it back
        wr_log.delete();
        gl_txn(1'b1, ta(3, 4), SHIP, 2, 0);
        check("gl_write_count", wr_log.size(), 1);
        if (wr_log.size() > 0) check("gl_write_value", wr_log[0], int'(ta(3, 4)) * 4 + 3);
        gl_txn(1'b0, ta(3, 4), 2'd0, 2, 0);

        // Fill the board, then random game traffic
        prefill();
        for (int i = 0; i < 40; i++)
            gl_txn(1'($urandom_range(0, 1)), ta($urandom_range(0, W - 1), $urandom_range(0, H - 1)),
                   2'($urandom_range(0, 3)), 2, 0);

        // Video holds the port for 50 cycles while a game read waits
        fork
            gl_txn(1'b0, ta(5, 6), 2'd0, 52, 0);
            begin
                for (int i = 0; i < 50; i++) begin
                    vid_rd_en = 1'b1;
                    vid_addr  = ta($urandom_range(0, W - 1), $urandom_range(0, H - 1));
                    vid_q.push_back(ref_b[vid_addr]);
                    tick;
                end
                vid_rd_en = 1'b0;
            end
        join

        // Full clear with video idle
        wr_log.delete();
        start_clear_model();
        clr_start = 1'b1;
        @(negedge clk);
        check("clr_busy_cycle0", int'(clr_busy), 0);
        tick;
        clr_start = 1'b0;
        @(negedge clk);
        check("clr_busy_cycle1", int'(clr_busy), 1);
        k = 1;
        while (!clr_done && k < 400) begin
            tick;
            k++;
            @(negedge clk);
        end
        check("clr_done_cycle", k, 101);
        check("clr_busy_at_done", int'(clr_busy), 0);
        tick;
        check("clear_write_errors", clear_order_errors(100), 0);
        gl_txn(1'b0, ta(9, 9), 2'd0, 2, 0);

        // Clear with video every other cycle
        prefill();
        wr_log.delete();
        start_clear_model();
        clr_start = 1'b1;
        tick;
        clr_start = 1'b0;
        cleared = 0;
        k = 1;
        while (cleared < W * H && k < 1000) begin
            if (k % 2 == 1) begin
                x = $urandom_range(0, W - 1);
                y = $urandom_range(0, H - 1);
                idx = x * H + y;
                vid_rd_en = 1'b1;
                vid_addr  = ta(x, y);
                vid_q.push_back((idx < cleared) ? 0 : pre_b[ta(x, y)]);
            end else begin
                vid_rd_en = 1'b0;
                cleared++;
            end
            tick;
            k++;
        end
        vid_rd_en = 1'b0;
        @(negedge clk);
        check("toggle_clr_done", int'(clr_done), 1);
        tick;
        check("toggle_write_errors", clear_order_errors(100), 0);

        // clr_start during GL_CAP: game ack first, then a read waits for the clear
        prefill();
        fork
            gl_txn(1'b0, ta(3, 4), 2'd0, 2, 0);
            begin
                tick;
                clr_start = 1'b1;
                tick;
                clr_start = 1'b0;
            end
        join
        start_clear_model();
        t_done = 0;
        check("busy_after_cap_start", int'(clr_busy), 1);
        gl_txn(1'b0, ta(7, 2), 2'd0, -1, 0);
        check("ack_after_clr_done", int'(t_done != 0 && t_ack > t_done), 1);

        // Out-of-range game write {12,3}
        wr_log.delete();
`ifdef BOARD_ARB_RANGE_CHECK_EN
        gl_txn(1'b1, ta(12, 3), SHIP, 2, 1);
        check("oor_write_count", wr_log.size(), 0);
`else
        gl_txn(1'b1, ta(12, 3), SHIP, 2, 0);
        check("oor_write_count", wr_log.size(), 1);
        if (wr_log.size() > 0) check("oor_write_value", wr_log[0], int'(ta(12, 3)) * 4 + 3);
`endif

        // Reset mid-clear abandons it: no done pulse afterwards
        clr_start = 1'b1;
        tick;
        clr_start = 1'b0;
        repeat (20) tick;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (clr_done) seen++;
        end
        check("no_done_after_abort", seen, 0);
        check("busy_after_abort", int'(clr_busy), 0);
        check("gl_queue_empty", gl_q.size(), 0);
        check("vid_queue_empty", vid_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
